manchester_codec: RTL and testbench
===================================

// Module: manchester_codec
// PURPOSE
//  Byte-level Manchester link endpoint, one clock domain, one half-bit per aclk.
//  TX: AXI-Stream bytes in -> serial_out, MSB first, no byte stuffing (host pre-escapes).
//  RX: manchester_in -> hunt SFD -> FRAME_SIZE unescaped payload bytes out on AXI-Stream.
//  Used as a point-to-point framed serial link; the bench loops serial_out to manchester_in.
// PARAMETERS
//  FRAME_SIZE  4  payload bytes per frame after SFD; escape pairs count as one byte
// PORTS
//  aclk           in   1  clock; one clock for the whole block
//  areset         in   1  reset; asynchronous, active-high
//  s_axis_tdata   in   8  TX byte
//  s_axis_tvalid  in   1  TX byte valid
//  s_axis_tready  out  1  TX can accept a byte
//  serial_out     out  1  Manchester line out; idle low
//  manchester_in  in   1  Manchester line in, synchronous to aclk
//  m_axis_tdata   out  8  decoded payload byte
//  m_axis_tvalid  out  1  payload byte valid
//  m_axis_tready  in   1  sink ready
// BEHAVIOUR
//  Coding: bit 1 = half-bits 0,1 (low->high); bit 0 = half-bits 1,0. Each half-bit lasts one aclk.
//  Reset values: s_axis_tready=0, serial_out=0, m_axis_tvalid=0, m_axis_tdata=0; all state idle/HUNT.
//  TX:
//   - One holding register plus one 16-half-bit shifter. s_axis_tready is registered = !hold_full;
//     it rises the first cycle after reset release.
//   - Accept on tvalid&tready; tready is 0 the very next cycle, so no double accept.
//   - Hold moves to the shifter no earlier than 1 cycle after load, and only when the shifter
//     is empty or on its last half-bit.
//   - serial_out is registered: first half-bit appears the cycle after the shifter load.
//   - Back-to-back bytes are gap-free if the next byte is held before the last half-bit.
//   - Shifter empty with hold empty -> serial_out=0.
//  RX (states HUNT, PAYLOAD):
//   - HUNT: sample manchester_in every cycle into a 16-bit history.
//     History == 16'h5999 (Manchester of SFD 8'hD5) -> PAYLOAD. This sets pair and byte phase.
//   - PAYLOAD: decode one pair per 2 cycles. Equal halves (00/11) = code violation -> abort to HUNT.
//     Every 8 bits yields a raw byte R:
//       R==ESC(8'hE5) -> set esc flag, no output.
//       esc && R==REPLACE(8'hF5) -> output 8'hD5.
//       esc && other R -> output R literally.
//       !esc && R==SFD -> restart frame: count=0, stay in PAYLOAD.
//       else -> output R.
//   - After FRAME_SIZE outputs -> HUNT.
//   - Output register: m_axis_tvalid asserts the cycle after the byte's last half-bit is sampled.
//     It is held with m_axis_tdata stable until m_axis_tready.
//     A new byte arriving while tvalid&&!tready is dropped.
//   - Preamble, SFD and ESC bytes are never output.
//  Reset mid-operation: all registers clear asynchronously. Any partial frame is discarded.
//   serial_out returns low immediately.
// STRUCTURE
//  Package manchester_pkg: SFD=8'hD5, ESC=8'hE5, REPLACE=8'hF5, SFD_CODE=16'h5999,
//   and the RX state enum.
//  Sub-module manchester_rx (HUNT/PAYLOAD, unescape, output register). TX stays in the top.
// TESTING
//  - Reset: areset high 3 cycles -> tready=0, serial_out=0, m_axis_tvalid=0.
//    Then tready=1 one cycle after release.
//  - TX AA,AA,D5,F0,0F,AA,AA with tvalid held 2 cycles past accept (loopback)
//    -> exactly one accept per byte; RX emits F0,0F,AA,AA in order.
//  - TX AA,AA,D5,F0,0F,AA,E5,F5 -> RX emits F0,0F,AA,D5; no output for AA/D5/E5.
//  - serial_out for byte 8'hAA -> 0,1,1,0,0,1,1,0,0,1,1,0,0,1,1,0; idle low after.
//  - Inject 11 pair mid-payload -> frame aborted, next AA,AA,D5,... frame decodes correctly.
//  - m_axis_tready=0 during frame -> first byte held stable; later bytes dropped; no spurious tvalid.

Source files
------------

// File: rtl/manchester_pkg.sv
// Shared constants, RX state type and the byte-to-half-bit encoder for the Manchester link.
package manchester_pkg;

   localparam logic [7:0]  SFD      = 8'hD5;
   localparam logic [7:0]  ESC      = 8'hE5;
   localparam logic [7:0]  REPLACE  = 8'hF5;
   localparam logic [15:0] SFD_CODE = 16'h5999;

   typedef enum logic {
      HUNT    = 1'b0,
      PAYLOAD = 1'b1
   } rx_state_t;

   // MSB-first half-bit sequence; code[15] goes on the line first. 1 -> 01, 0 -> 10.
   function automatic logic [15:0] manchester_encode(input logic [7:0] data);
      logic [15:0] code;
      code = '0;
      for (int i = 0; i < 8; i++) begin
         code[2*i +: 2] = data[i] ? 2'b01 : 2'b10;
      end
      return code;
   endfunction

endpackage

// File: rtl/manchester_rx.sv
// Manchester receiver: SFD hunt, pair decode, unescape and a single-entry output register.
//
// state   | meaning
// --------+------------------------------------------------------------
// HUNT    | shift every sample into history, wait for the SFD code word
// PAYLOAD | decode one pair per two cycles, unescape, emit FRAME_SIZE bytes
module manchester_rx
   import manchester_pkg::*;
#(
   parameter int FRAME_SIZE = 4
) (
   input  logic       aclk,
   input  logic       areset,
   input  logic       manchester_in,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready
);

   localparam int            CW        = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
   localparam logic [CW-1:0] LAST_BYTE = CW'(FRAME_SIZE - 1);

   rx_state_t     state;
   logic [15:0]   history;
   logic          first_half;
   logic          second_phase;
   logic [2:0]    bit_cnt;
   logic [6:0]    bits;
   logic          esc;
   logic [CW-1:0] byte_cnt;

   logic [15:0]   hist_nxt;
   logic          violation;
   logic [7:0]    raw;
   logic          byte_done;
   logic          emit;
   logic [7:0]    emit_data;

   always_comb begin
      hist_nxt  = {history[14:0], manchester_in};
      violation = (first_half == manchester_in);
      raw       = {bits, manchester_in};
      byte_done = (state == PAYLOAD) && second_phase && !violation && (bit_cnt == 3'd7);
      emit      = byte_done && (esc || ((raw != ESC) && (raw != SFD)));
      emit_data = (esc && (raw == REPLACE)) ? SFD : raw;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state         <= HUNT;
         history       <= '0;
         first_half    <= 1'b0;
         second_phase  <= 1'b0;
         bit_cnt       <= '0;
         bits          <= '0;
         esc           <= 1'b0;
         byte_cnt      <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
      end else begin
         history <= hist_nxt;

         if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end

         case (state)
            HUNT: begin
               // The SFD match fixes pair alignment: the next sample is a first half.
               if (hist_nxt == SFD_CODE) begin
                  state        <= PAYLOAD;
                  second_phase <= 1'b0;
                  bit_cnt      <= '0;
                  esc          <= 1'b0;
                  byte_cnt     <= '0;
               end
            end
            PAYLOAD: begin
               if (!second_phase) begin
                  first_half   <= manchester_in;
                  second_phase <= 1'b1;
               end else begin
                  second_phase <= 1'b0;
                  if (violation) begin
                     state <= HUNT;
                  end else if (bit_cnt != 3'd7) begin
                     bits    <= {bits[5:0], manchester_in};
                     bit_cnt <= bit_cnt + 3'd1;
                  end else begin
                     bit_cnt <= '0;
                     if (esc) begin
                        esc <= 1'b0;
                     end else if (raw == ESC) begin
                        esc <= 1'b1;
                     end else if (raw == SFD) begin
                        byte_cnt <= '0;
                     end
                  end
               end
            end
            default: state <= HUNT;
         endcase

         // A byte that finds the output register still occupied is dropped but still counts.
         if (emit) begin
            if (!m_axis_tvalid || m_axis_tready) begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= emit_data;
            end
            if (byte_cnt == LAST_BYTE) begin
               state <= HUNT;
            end else begin
               byte_cnt <= byte_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/manchester_codec.sv
// Byte-level Manchester link endpoint: TX hold register + 16 half-bit shifter, RX in manchester_rx.
module manchester_codec
   import manchester_pkg::*;
#(
   parameter int FRAME_SIZE = 4
) (
   input  logic       aclk,
   input  logic       areset,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic       serial_out,
   input  logic       manchester_in,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready
);

   logic [7:0]  hold_data;
   logic        hold_full;
   logic [15:0] hold_code;
   logic [15:0] shift_q;
   logic [3:0]  half_cnt;
   logic        accept;
   logic        move;

   // half_cnt == 0 covers both an idle shifter and one showing its last half-bit.
   always_comb begin
      hold_code = manchester_encode(hold_data);
      accept    = s_axis_tvalid && s_axis_tready;
      move      = hold_full && (half_cnt == 4'd0);
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         s_axis_tready <= 1'b0;
         serial_out    <= 1'b0;
         hold_data     <= '0;
         hold_full     <= 1'b0;
         shift_q       <= '0;
         half_cnt      <= '0;
      end else begin
         // Stays low through the cycle the hold drains, so a lingering tvalid is not re-accepted.
         s_axis_tready <= !(accept || hold_full);

         if (accept) begin
            hold_data <= s_axis_tdata;
            hold_full <= 1'b1;
         end else if (move) begin
            hold_full <= 1'b0;
         end

         if (move) begin
            serial_out <= hold_code[15];
            shift_q    <= {hold_code[14:0], 1'b0};
            half_cnt   <= 4'd15;
         end else if (half_cnt != 4'd0) begin
            serial_out <= shift_q[15];
            shift_q    <= {shift_q[14:0], 1'b0};
            half_cnt   <= half_cnt - 4'd1;
         end else begin
            serial_out <= 1'b0;
         end
      end
   end

   manchester_rx #(
      .FRAME_SIZE(FRAME_SIZE)
   ) u_rx (
      .aclk          (aclk),
      .areset        (areset),
      .manchester_in (manchester_in),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

endmodule

// File: tb/tb_manchester_codec.sv
// Directed loopback bench for manchester_codec; serial_out feeds manchester_in unless raw-driven.
module tb_manchester_codec;

   logic       aclk;
   logic       areset;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid;
   logic       s_axis_tready;
   logic       serial_out;
   logic       manchester_in;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;

   logic       use_raw;
   logic       raw_line;

   int         checks;
   int         errors;
   int         acc_cnt;
   logic [7:0] rxq[$];

   logic       hold_watch;
   logic       hold_seen;
   int         hold_bad;

   logic [7:0] f_plain [8] = '{8'hAA, 8'hAA, 8'hD5, 8'hF0, 8'h0F, 8'hAA, 8'hAA, 8'h00};
   logic [7:0] f_esc   [8] = '{8'hAA, 8'hAA, 8'hD5, 8'hF0, 8'h0F, 8'hAA, 8'hE5, 8'hF5};
   logic [7:0] e_plain [8] = '{8'hF0, 8'h0F, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] e_esc   [8] = '{8'hF0, 8'h0F, 8'hAA, 8'hD5, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] e_abort [8] = '{8'h12, 8'hF0, 8'h0F, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00};
   logic [15:0] aa_line = 16'b0110_0110_0110_0110;

   assign manchester_in = use_raw ? raw_line : serial_out;

   manchester_codec #(
      .FRAME_SIZE(4)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .serial_out    (serial_out),
      .manchester_in (manchester_in),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   always @(negedge aclk) begin
      if (m_axis_tvalid && m_axis_tready) rxq.push_back(m_axis_tdata);
      if (s_axis_tvalid && s_axis_tready) acc_cnt++;
      if (hold_watch) begin
         if (m_axis_tvalid) begin
            hold_seen = 1'b1;
            if (m_axis_tdata != 8'hF0) hold_bad++;
         end else if (hold_seen) begin
            hold_bad++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tx_byte(input logic [7:0] b, input int hold);
      int waited;
      waited = 0;
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      @(negedge aclk);
      while (!s_axis_tready && waited < 100) begin
         @(negedge aclk);
         waited++;
      end
      if (!s_axis_tready) check("tx_accept_timeout", 32'd0, 32'd1);
      @(posedge aclk); #1;
      repeat (hold) begin
         @(posedge aclk); #1;
      end
   endtask

   task automatic tx_frame(input logic [7:0] b [8], input int n);
      for (int k = 0; k < n; k++) tx_byte(b[k], 2);
      s_axis_tvalid = 1'b0;
      repeat (60) @(posedge aclk);
      #1;
   endtask

   task automatic drive_half(input logic v);
      raw_line = v;
      @(posedge aclk); #1;
   endtask

   task automatic drive_raw_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         if (b[i]) begin
            drive_half(1'b0); drive_half(1'b1);
         end else begin
            drive_half(1'b1); drive_half(1'b0);
         end
      end
   endtask

   task automatic check_rx(input string tag, input logic [7:0] e [8], input int n);
      check({tag, "_count"}, rxq.size(), n);
      for (int k = 0; k < n; k++) begin
         check($sformatf("%s_byte%0d", tag, k), (k < rxq.size()) ? 32'(rxq[k]) : 32'hdead, 32'(e[k]));
      end
      rxq.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      int ones;
      checks        = 0;
      errors        = 0;
      acc_cnt       = 0;
      areset        = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      use_raw       = 1'b0;
      raw_line      = 1'b0;
      hold_watch    = 1'b0;
      hold_seen     = 1'b0;
      hold_bad      = 0;

      // reset
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_tready", 32'(s_axis_tready), 32'd0);
      check("rst_serial", 32'(serial_out), 32'd0);
      check("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_mdata", 32'(m_axis_tdata), 32'd0);
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      check("tready_before_edge", 32'(s_axis_tready), 32'd0);
      @(negedge aclk);
      check("tready_after_release", 32'(s_axis_tready), 32'd1);
      @(posedge aclk); #1;

      // plain frame with tvalid lingering past each accept
      acc_cnt = 0;
      rxq.delete();
      tx_frame(f_plain, 7);
      check("plain_accepts", acc_cnt, 7);
      check_rx("plain", e_plain, 4);

      // escaped frame
      acc_cnt = 0;
      tx_frame(f_esc, 8);
      check("esc_accepts", acc_cnt, 8);
      check_rx("esc", e_esc, 4);

      // serial waveform of a single AA
      s_axis_tdata  = 8'hAA;
      s_axis_tvalid = 1'b1;
      waited = 0;
      @(negedge aclk);
      while (!s_axis_tready && waited < 100) begin
         @(negedge aclk);
         waited++;
      end
      if (!s_axis_tready) check("aa_accept_timeout", 32'd0, 32'd1);
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0;
      @(posedge aclk);
      for (int i = 0; i < 16; i++) begin
         @(negedge aclk);
         check($sformatf("aa_half%0d", i), 32'(serial_out), 32'(aa_line[15-i]));
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         check($sformatf("aa_idle%0d", i), 32'(serial_out), 32'd0);
      end
      repeat (20) @(posedge aclk);
      #1;
      check("aa_no_output", rxq.size(), 0);
      rxq.delete();

      // code violation mid-payload, then a clean frame
      use_raw  = 1'b1;
      raw_line = 1'b0;
      drive_raw_byte(8'hAA);
      drive_raw_byte(8'hAA);
      drive_raw_byte(8'hD5);
      drive_raw_byte(8'h12);
      drive_half(1'b1);
      drive_half(1'b1);
      for (int i = 0; i < 20; i++) drive_half(1'b0);
      use_raw = 1'b0;
      tx_frame(f_plain, 7);
      check_rx("abort", e_abort, 5);

      // sink stalled for a whole frame
      m_axis_tready = 1'b0;
      hold_watch    = 1'b1;
      tx_frame(f_plain, 7);
      hold_watch = 1'b0;
      @(negedge aclk);
      check("stall_valid", 32'(m_axis_tvalid), 32'd1);
      check("stall_data", 32'(m_axis_tdata), 32'hF0);
      check("stall_unstable", hold_bad, 0);
      check("stall_no_xfer", rxq.size(), 0);
      @(posedge aclk); #1;
      m_axis_tready = 1'b1;
      @(negedge aclk);
      @(negedge aclk);
      check("stall_valid_cleared", 32'(m_axis_tvalid), 32'd0);
      repeat (40) @(posedge aclk);
      #1;
      check_rx("stall", e_plain, 1);

      // asynchronous reset while a byte is on the line
      tx_byte(8'hFF, 0);
      s_axis_tvalid = 1'b0;
      waited = 0;
      @(negedge aclk);
      while (!serial_out && waited < 40) begin
         @(negedge aclk);
         waited++;
      end
      check("midrst_line_high", 32'(serial_out), 32'd1);
      #1;
      areset = 1'b1;
      #1;
      check("midrst_serial", 32'(serial_out), 32'd0);
      check("midrst_tready", 32'(s_axis_tready), 32'd0);
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
      ones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (serial_out) ones++;
      end
      check("midrst_line_idle", ones, 0);
      check("midrst_tready_back", 32'(s_axis_tready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
